note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays a stored sequence of musical notes by driving the note code (TOM plus A, B, C) into the seven-segment note display decoder. Each note is held for a programmable duration. It sits between the front-panel controls (start, stop, pause, loop) and the display decoder, and it is the only block that drives the decoder's inputs. A small register-file program memory holds the steps and is written through a simple write port.

## Interface
Parameters:
- STEPS, default 16: number of program steps; a power of two, at least 2.
- DUR_W, default 8: width of the per-step duration field.
- PRESCALE, default 50000: clock cycles per duration unit; at least 2.

Ports:
- Clock  in  1  single clock; everything is on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state, including program memory.
- Start  in  1  begins playback from step 0; sampled only while idle.
- Stop  in  1  aborts playback immediately; has priority over Start and Pause.
- Pause  in  1  level input; freezes playback while high.
- Loop  in  1  level input; sampled at the end of the sequence; when high, playback restarts at step 0.
- WrEn  in  1  program memory write strobe.
- WrAddr  in  $clog2(STEPS)  write address.
- WrData  in  4+DUR_W  program entry: {tom, note[2:0], dur[DUR_W-1:0]}.
- TOM  out  1  note modifier bit, to the decoder.
- A, B, C  out  1 each  note index bits (A is the MSB), to the decoder.
- NoteValid  out  1  high while a note is being presented.
- StepIdx  out  $clog2(STEPS)  index of the current step.
- Busy  out  1  high in PLAY and PAUSED.
- Done  out  1  one-cycle pulse when the sequence ends without looping.

## Operation
- Entry with dur == 0: end-of-sequence marker. Reaching the last step (STEPS-1) and completing it also ends the sequence.
- Memory: register array with combinational read. A write takes effect on the next cycle.
  - Writes are allowed at any time.
  - Writing the step currently playing does not change its loaded duration or its outputs.
- States: IDLE, PLAY, PAUSED.
- IDLE:
  - Outputs TOM/A/B/C/NoteValid/Busy = 0, StepIdx = 0.
  - On Start with Stop low, read step 0:
    - dur ≠ 0: load its tom/note into the output registers, remaining = dur, prescaler = 0, go to PLAY.
    - dur == 0: pulse Done, stay in IDLE.
- PLAY:
  - The prescaler counts 0..PRESCALE-1; its wrap produces a tick.
  - Each tick decrements remaining.
  - On the tick that takes remaining to 0, advance:
    - next = StepIdx+1. If StepIdx == STEPS-1 or entry[next].dur == 0, the sequence ends.
    - Sequence end with Loop high: restart at step 0, or go to IDLE with Done if step 0 has dur == 0.
    - Sequence end with Loop low: pulse Done, go to IDLE.
    - Otherwise load entry[next] the same cycle, with no gap.
- PAUSED:
  - Entered from PLAY when Pause is high; returns to PLAY when Pause is low.
  - Prescaler, remaining, outputs and NoteValid are all held.
- Stop high in PLAY or PAUSED: go to IDLE next cycle, with no Done.
- Start while Busy is ignored.
- Pause high together with the final tick: Pause wins, and the tick is not consumed.

## Timing
- All outputs are registered. Reset values are all 0, and the state is IDLE.
- Start sampled in cycle n: NoteValid = 1 and the step-0 note appear in cycle n+1.
- Step k is presented for exactly dur_k × PRESCALE cycles of non-paused PLAY.
- Done is asserted in the cycle after the last cycle of the final note, together with NoteValid = 0.
- Reset mid-playback: everything returns to reset values on the next edge, and memory contents are lost.
- The duration arithmetic is DUR_W bits and unsigned. The maximum note length is (2^DUR_W − 1) × PRESCALE cycles.

## Structure
- Package note_seq_pkg holds:
  - the state enum (IDLE, PLAY, PAUSED);
  - field offsets and widths of a program entry (DUR_LSB, NOTE_LSB, TOM_BIT);
  - the localparam ENTRY_W = 4 + DUR_W.
- One sub-module, tick_prescaler (parameter PRESCALE; inputs Clock, Reset, clear, enable; output tick), holds the cycle counter.
- The FSM, step pointer, remaining counter and memory stay in note_sequencer.

## Test plan
Run with PRESCALE=4, STEPS=8, DUR_W=4.
- Program steps 0..2 = {0,3'b001,2}, {1,3'b100,1}, {0,3'b111,3} with step 3 dur 0; pulse Start at cycle 10. Required: TOM/A/B/C = 0/001 for cycles 11–18, 1/100 for cycles 19–22, 0/111 for cycles 23–34, then Done = 1 in cycle 35.
- Same program with Loop = 1. Required: the note is 0/001 again in cycle 35, with no Done.
- Hold Pause high for 5 cycles starting at cycle 13. Required: outputs frozen during the pause, and step 0 ends 5 cycles later (cycle 23).
- Assert Start and Stop together in IDLE: required to stay IDLE. Assert Stop in cycle 20: required Busy = 0 and NoteValid = 0 in cycle 21, with no Done.
- Step 0 has dur = 0; pulse Start. Required: Done in the next cycle, NoteValid never asserted.
- Program all 8 steps with dur = 1 and pulse Start. Required: StepIdx 0..7, 4 cycles each, Done after step 7. Then assert Reset mid-run: all outputs 0 next cycle, and memory reads 0.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// Shared state type and program-entry layout for the note sequencer.
// Entry layout is {tom, note[2:0], dur[DUR_W-1:0]}; offsets depend on DUR_W.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PLAY   = 2'b01,
    PAUSED = 2'b10
  } seq_state_e;

  localparam int NOTE_W  = 3;
  localparam int DUR_LSB = 0;

  function automatic int note_lsb(input int dur_w);
    return DUR_LSB + dur_w;
  endfunction

  function automatic int tom_bit(input int dur_w);
    return note_lsb(dur_w) + NOTE_W;
  endfunction

  function automatic int entry_w(input int dur_w);
    return tom_bit(dur_w) + 32'sd1;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Front-panel controls, program write port and decoder drive of the note sequencer.
interface note_sequencer_if #(
  parameter int STEPS = 16,
  parameter int DUR_W = 8
);
  localparam int IDX_W   = $clog2(STEPS);
  localparam int ENTRY_W = note_seq_pkg::entry_w(DUR_W);

  logic               Start;
  logic               Stop;
  logic               Pause;
  logic               Loop;
  logic               WrEn;
  logic [IDX_W-1:0]   WrAddr;
  logic [ENTRY_W-1:0] WrData;
  logic               TOM;
  logic               A;
  logic               B;
  logic               C;
  logic               NoteValid;
  logic [IDX_W-1:0]   StepIdx;
  logic               Busy;
  logic               Done;

  modport master (
    output Start, Stop, Pause, Loop, WrEn, WrAddr, WrData,
    input  TOM, A, B, C, NoteValid, StepIdx, Busy, Done
  );

  modport slave (
    input  Start, Stop, Pause, Loop, WrEn, WrAddr, WrData,
    output TOM, A, B, C, NoteValid, StepIdx, Busy, Done
  );

endinterface

// File: rtl/note_sequencer_tick_prescaler.sv
// Divides the clock into duration units: tick is high on the last cycle of
// each PRESCALE-cycle window while enabled.
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int                CNT_W    = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_r;

  assign tick = enable && (count_r == CNT_LAST);

  // Window counter; it only advances while enabled, so a hold freezes it in place.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      if (count_r == CNT_LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + 1'b1;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays a stored note program into the seven-segment note decoder, one
// programmable-length step at a time, with stop, pause and loop control.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int STEPS    = 16,
  parameter int DUR_W    = 8,
  parameter int PRESCALE = 50000
) (
  input  logic            Clock,
  input  logic            Reset,
  note_sequencer_if.slave bus
);

  localparam int                IDX_W      = $clog2(STEPS);
  localparam int                ENTRY_W    = entry_w(DUR_W);
  localparam int                NOTE_LSB   = note_lsb(DUR_W);
  localparam int                TOM_BIT    = tom_bit(DUR_W);
  localparam logic [IDX_W-1:0]  FIRST_STEP = '0;
  localparam logic [IDX_W-1:0]  LAST_STEP  = IDX_W'(STEPS - 1);
  localparam logic [DUR_W-1:0]  DUR_ONE    = DUR_W'(1'b1);

  logic [ENTRY_W-1:0] mem_r [STEPS];

  seq_state_e         state_r, state_nxt_s;
  logic [IDX_W-1:0]   step_r, step_nxt_s;
  logic [DUR_W-1:0]   remaining_r, remaining_nxt_s;
  logic               tom_r, tom_nxt_s;
  logic [NOTE_W-1:0]  note_r, note_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;

  logic [ENTRY_W-1:0] first_entry_s, next_entry_s, load_entry_s;
  logic [IDX_W-1:0]   next_idx_s;
  logic               first_zero_s, next_zero_s, seq_end_s, restart_ok_s;
  logic               busy_st_s, start_ok_s, running_s, tick_s, final_tick_s;
  logic               load_first_s, load_next_s, prescale_clr_s;

  assign next_idx_s    = step_r + 1'b1;
  assign first_entry_s = mem_r[FIRST_STEP];
  assign next_entry_s  = mem_r[next_idx_s];
  assign first_zero_s  = (first_entry_s[DUR_LSB +: DUR_W] == '0);
  assign next_zero_s   = (next_entry_s[DUR_LSB +: DUR_W] == '0);
  assign seq_end_s     = (step_r == LAST_STEP) || next_zero_s;
  assign restart_ok_s  = bus.Loop && !first_zero_s;

  // Counting runs in PAUSED too once Pause drops, so the resume cycle is not lost.
  assign busy_st_s      = (state_r == PLAY) || (state_r == PAUSED);
  assign start_ok_s     = (state_r == IDLE) && bus.Start && !bus.Stop;
  assign running_s      = busy_st_s && !bus.Stop && !bus.Pause;
  assign final_tick_s   = running_s && tick_s && (remaining_r == DUR_ONE);
  assign load_first_s   = (start_ok_s && !first_zero_s) ||
                          (final_tick_s && seq_end_s && restart_ok_s);
  assign load_next_s    = final_tick_s && !seq_end_s;
  assign load_entry_s   = load_first_s ? first_entry_s : next_entry_s;
  assign prescale_clr_s = (state_r == IDLE);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (prescale_clr_s),
    .enable (running_s),
    .tick   (tick_s)
  );

  // Program memory: cleared by reset, writable at any time, read combinationally.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < STEPS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (bus.WrEn) begin
      mem_r[bus.WrAddr] <= bus.WrData;
    end
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= IDLE;
      step_r      <= '0;
      remaining_r <= '0;
      tom_r       <= 1'b0;
      note_r      <= '0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      step_r      <= step_nxt_s;
      remaining_r <= remaining_nxt_s;
      tom_r       <= tom_nxt_s;
      note_r      <= note_nxt_s;
      valid_r     <= valid_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  // Next-state logic; Stop outranks Pause, and Pause outranks a pending final tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s && !first_zero_s) begin
          state_nxt_s = PLAY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PLAY, PAUSED: begin
        if (bus.Stop) begin
          state_nxt_s = IDLE;
        end else if (bus.Pause) begin
          state_nxt_s = PAUSED;
        end else if (final_tick_s && seq_end_s && !restart_ok_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PLAY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next output values: a step is copied into registers on load, so rewriting it later has no effect.
  always_comb begin
    step_nxt_s      = step_r;
    remaining_nxt_s = remaining_r;
    tom_nxt_s       = tom_r;
    note_nxt_s      = note_r;
    valid_nxt_s     = valid_r;
    busy_nxt_s      = busy_r;
    done_nxt_s      = (start_ok_s && first_zero_s) ||
                      (final_tick_s && seq_end_s && !restart_ok_s);
    if (state_nxt_s == IDLE) begin
      step_nxt_s      = '0;
      remaining_nxt_s = '0;
      tom_nxt_s       = 1'b0;
      note_nxt_s      = '0;
      valid_nxt_s     = 1'b0;
      busy_nxt_s      = 1'b0;
    end else if (load_first_s || load_next_s) begin
      step_nxt_s      = load_first_s ? FIRST_STEP : next_idx_s;
      remaining_nxt_s = load_entry_s[DUR_LSB +: DUR_W];
      tom_nxt_s       = load_entry_s[TOM_BIT];
      note_nxt_s      = load_entry_s[NOTE_LSB +: NOTE_W];
      valid_nxt_s     = 1'b1;
      busy_nxt_s      = 1'b1;
    end else if (running_s && tick_s) begin
      remaining_nxt_s = remaining_r - DUR_ONE;
    end else begin
      remaining_nxt_s = remaining_r;
    end
  end

  assign bus.TOM       = tom_r;
  assign bus.A         = note_r[2];
  assign bus.B         = note_r[1];
  assign bus.C         = note_r[0];
  assign bus.NoteValid = valid_r;
  assign bus.StepIdx   = step_r;
  assign bus.Busy      = busy_r;
  assign bus.Done      = done_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed timelines plus randomized
// traffic checked against a cycle-budget model of the playback rules.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int STEPS    = 8;
  localparam int DUR_W    = 4;
  localparam int PRESCALE = 4;
  localparam int IDX_W    = $clog2(STEPS);
  localparam int ENTRY_W  = entry_w(DUR_W);
  localparam int VW       = 7 + IDX_W;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  note_sequencer_if #(.STEPS(STEPS), .DUR_W(DUR_W)) bus ();

  note_sequencer #(
    .STEPS    (STEPS),
    .DUR_W    (DUR_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  // Reference model: a note lasts dur*PRESCALE cycles in which Pause is low.
  logic [ENTRY_W-1:0] m_mem [STEPS];
  bit                 m_play;
  bit                 m_done;
  int                 m_idx;
  int                 m_used;
  int                 m_len;
  logic [3:0]         m_note;

  function automatic int dur_of(input logic [ENTRY_W-1:0] e);
    return int'(e[DUR_W-1:0]);
  endfunction

  function automatic void m_load(input int i);
    m_play = 1'b1;
    m_idx  = i;
    m_used = 0;
    m_len  = dur_of(m_mem[i]) * PRESCALE;
    m_note = m_mem[i][ENTRY_W-1:DUR_W];
  endfunction

  function automatic void model_update();
    bit last;
    m_done = 1'b0;
    if (rst) begin
      for (int i = 0; i < STEPS; i++) m_mem[i] = '0;
      m_play = 1'b0;
      m_idx  = 0;
      m_note = 4'h0;
      return;
    end
    if (!m_play) begin
      if (bus.Start && !bus.Stop) begin
        if (dur_of(m_mem[0]) == 0) m_done = 1'b1;
        else m_load(0);
      end
    end else if (bus.Stop) begin
      m_play = 1'b0;
    end else if (!bus.Pause) begin
      m_used++;
      if (m_used == m_len) begin
        last = (m_idx == STEPS - 1) ? 1'b1 : (dur_of(m_mem[m_idx + 1]) == 0);
        if (!last) m_load(m_idx + 1);
        else if (bus.Loop && dur_of(m_mem[0]) != 0) m_load(0);
        else begin
          m_play = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    if (bus.WrEn) m_mem[bus.WrAddr] = bus.WrData;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_play ? m_note : 4'h0, m_play,
            m_play ? IDX_W'(m_idx) : {IDX_W{1'b0}}, m_play, m_done};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.TOM, bus.A, bus.B, bus.C, bus.NoteValid, bus.StepIdx, bus.Busy, bus.Done};
  endfunction

  function automatic logic [VW-1:0] mk(input logic t, input logic [2:0] n, input logic v,
                                       input int idx, input logic b, input logic d);
    return {t, n, v, IDX_W'(idx), b, d};
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.Start  = 1'b0;
    bus.Stop   = 1'b0;
    bus.Pause  = 1'b0;
    bus.Loop   = 1'b0;
    bus.WrEn   = 1'b0;
    bus.WrAddr = '0;
    bus.WrData = '0;
  endtask

  task automatic write_entry(input int addr, input logic [ENTRY_W-1:0] data);
    bus.WrEn   = 1'b1;
    bus.WrAddr = IDX_W'(addr);
    bus.WrData = data;
    step_cycle();
    bus.WrEn   = 1'b0;
  endtask

  task automatic program_basic();
    write_entry(0, {1'b0, 3'b001, 4'd2});
    write_entry(1, {1'b1, 3'b100, 4'd1});
    write_entry(2, {1'b0, 3'b111, 4'd3});
    write_entry(3, {1'b0, 3'b000, 4'd0});
    step_cycle();
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    step_cycle();
    bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step_cycle();
    step_cycle();
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", obs_vec(), {VW{1'b0}});
    end
    rst = 1'b0;
    pulse_start();
    checks++;
    if (obs_vec() !== mk(1'b0, 3'b000, 1'b0, 0, 1'b0, 1'b1)) begin
      failures++;
      $display("FAIL reset_mem_empty got=%h want=%h", obs_vec(), mk(1'b0, 3'b000, 1'b0, 0, 1'b0, 1'b1));
    end
    step_cycle();
  endtask

  task automatic test_basic();
    logic [VW-1:0] e;
    program_basic();
    pulse_start();
    for (int r = 1; r <= 26; r++) begin
      if (r <= 8)        e = mk(1'b0, 3'b001, 1'b1, 0, 1'b1, 1'b0);
      else if (r <= 12)  e = mk(1'b1, 3'b100, 1'b1, 1, 1'b1, 1'b0);
      else if (r <= 24)  e = mk(1'b0, 3'b111, 1'b1, 2, 1'b1, 1'b0);
      else if (r == 25)  e = mk(1'b0, 3'b000, 1'b0, 0, 1'b0, 1'b1);
      else               e = '0;
      checks++;
      if (obs_vec() !== e) begin
        failures++;
        $display("FAIL basic_timeline r=%0d got=%h want=%h", r, obs_vec(), e);
      end
      step_cycle();
    end
  endtask

  task automatic test_loop();
    bus.Loop = 1'b1;
    pulse_start();
    for (int r = 1; r <= 30; r++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL loop_model r=%0d got=%h want=%h", r, obs_vec(), exp_vec());
      end
      if (r == 25) begin
        checks++;
        if (obs_vec() !== mk(1'b0, 3'b001, 1'b1, 0, 1'b1, 1'b0)) begin
          failures++;
          $display("FAIL loop_restart got=%h want=%h", obs_vec(), mk(1'b0, 3'b001, 1'b1, 0, 1'b1, 1'b0));
        end
      end
      step_cycle();
    end
    bus.Loop = 1'b0;
    bus.Stop = 1'b1;
    step_cycle();
    bus.Stop = 1'b0;
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL loop_stop got=%h want=%h", obs_vec(), {VW{1'b0}});
    end
  endtask

  task automatic test_pause();
    pulse_start();
    for (int r = 1; r <= 28; r++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL pause_model r=%0d got=%h want=%h", r, obs_vec(), exp_vec());
      end
      if (r == 13 || r == 14) begin
        checks++;
        if (obs_vec() !== ((r == 13) ? mk(1'b0, 3'b001, 1'b1, 0, 1'b1, 1'b0)
                                     : mk(1'b1, 3'b100, 1'b1, 1, 1'b1, 1'b0))) begin
          failures++;
          $display("FAIL pause_step0_end r=%0d got=%h", r, obs_vec());
        end
      end
      bus.Pause = (r >= 3 && r <= 7);
      step_cycle();
    end
    bus.Pause = 1'b0;
    bus.Stop  = 1'b1;
    step_cycle();
    bus.Stop  = 1'b0;
  endtask

  task automatic test_stop();
    bus.Start = 1'b1;
    bus.Stop  = 1'b1;
    step_cycle();
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL start_stop_idle got=%h want=%h", obs_vec(), {VW{1'b0}});
    end
    pulse_start();
    for (int r = 1; r <= 12; r++) begin
      bus.Stop = (r == 10);
      step_cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stop_model r=%0d got=%h want=%h", r + 1, obs_vec(), exp_vec());
      end
    end
    bus.Stop = 1'b0;
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL stop_idle got=%h want=%h", obs_vec(), {VW{1'b0}});
    end
  endtask

  task automatic test_zero_first();
    write_entry(0, {1'b0, 3'b101, 4'd0});
    pulse_start();
    checks++;
    if (obs_vec() !== mk(1'b0, 3'b000, 1'b0, 0, 1'b0, 1'b1)) begin
      failures++;
      $display("FAIL zero_first_done got=%h want=%h", obs_vec(), mk(1'b0, 3'b000, 1'b0, 0, 1'b0, 1'b1));
    end
    for (int r = 2; r <= 4; r++) begin
      step_cycle();
      checks++;
      if (obs_vec() !== '0) begin
        failures++;
        $display("FAIL zero_first_quiet r=%0d got=%h want=%h", r, obs_vec(), {VW{1'b0}});
      end
    end
  endtask

  task automatic test_all_steps();
    logic [3:0]    notes [STEPS];
    logic [VW-1:0] e;
    int            idx;
    for (int i = 0; i < STEPS; i++) begin
      notes[i] = 4'($urandom);
      write_entry(i, {notes[i], 4'd1});
    end
    pulse_start();
    for (int r = 1; r <= 34; r++) begin
      idx = (r - 1) / PRESCALE;
      if (r <= STEPS * PRESCALE) e = mk(notes[idx][3], notes[idx][2:0], 1'b1, idx, 1'b1, 1'b0);
      else if (r == STEPS * PRESCALE + 1) e = mk(1'b0, 3'b000, 1'b0, 0, 1'b0, 1'b1);
      else e = '0;
      checks++;
      if (obs_vec() !== e) begin
        failures++;
        $display("FAIL all_steps r=%0d got=%h want=%h", r, obs_vec(), e);
      end
      step_cycle();
    end
    pulse_start();
    for (int r = 0; r < 6; r++) step_cycle();
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL reset_midrun got=%h want=%h", obs_vec(), {VW{1'b0}});
    end
    pulse_start();
    checks++;
    if (obs_vec() !== mk(1'b0, 3'b000, 1'b0, 0, 1'b0, 1'b1)) begin
      failures++;
      $display("FAIL reset_clears_mem got=%h want=%h", obs_vec(), mk(1'b0, 3'b000, 1'b0, 0, 1'b0, 1'b1));
    end
    step_cycle();
  endtask

  task automatic test_random();
    logic [DUR_W-1:0] d;
    for (int i = 0; i < STEPS; i++) begin
      d = ($urandom_range(9, 0) == 0) ? 4'hF : 4'($urandom_range(6, 1));
      write_entry(i, {4'($urandom), d});
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.Start  = ($urandom_range(3, 0) == 0);
      bus.Stop   = ($urandom_range(199, 0) == 0);
      bus.Pause  = ($urandom_range(9, 0) == 0);
      if ($urandom_range(63, 0) == 0) bus.Loop = ~bus.Loop;
      bus.WrEn   = ($urandom_range(15, 0) == 0);
      bus.WrAddr = IDX_W'($urandom_range(STEPS - 1, 0));
      d = ($urandom_range(9, 0) == 0) ? 4'hF : 4'($urandom_range(6, 0));
      bus.WrData = {4'($urandom), d};
      rst        = ($urandom_range(999, 0) == 0);
      step_cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_loop();
    test_pause();
    test_stop();
    test_zero_first();
    test_all_steps();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
